// File: rtl/regfile_sb.sv
// regfile_sb: DEPTH x WIDTH register file, NREAD combinational read ports, per-register busy scoreboard.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data onto matching read ports.
module regfile_sb #(
   parameter  int WIDTH    = 32,
   parameter  int DEPTH    = 32,
   parameter  int NREAD    = 2,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   we,
   input  logic [AW-1:0]          wa,
   input  logic [WIDTH-1:0]       wd,
   input  logic                   iss,
   input  logic [AW-1:0]          iss_a,
   input  logic [NREAD*AW-1:0]    ra,
   output logic [NREAD*WIDTH-1:0] rd,
   output logic [NREAD-1:0]       rbusy,
   output logic [DEPTH-1:0]       busy_vec
);
   function automatic logic [2**AW-1:0] range_mask();
      logic [2**AW-1:0] m;
      for (int i = 0; i < 2**AW; i++) m[i] = (i < DEPTH);
      return m;
   endfunction
   localparam logic [2**AW-1:0] VALID = range_mask();
   // An address is live when it names a real register other than a hard-wired zero.
   function automatic logic live(input logic [AW-1:0] a);
      return VALID[a] && !(ZERO_REG != 0 && a == '0);
   endfunction
   logic [WIDTH-1:0] rf_q [DEPTH];
   logic [WIDTH-1:0] rf_d [DEPTH];
   logic [DEPTH-1:0] busy_q, busy_d;
   logic             wr_ok, iss_ok;
   assign wr_ok  = reset_n && we && live(wa);
   assign iss_ok = reset_n && iss && live(iss_a);
   // Issue is applied after the write clear so a new producer supersedes the retiring one.
   always_comb begin
      rf_d   = rf_q;
      busy_d = busy_q;
      if (wr_ok) begin
         rf_d[wa]   = wd;
         busy_d[wa] = 1'b0;
      end
      if (iss_ok) busy_d[iss_a] = 1'b1;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
         busy_q <= '0;
      end else begin
         rf_q   <= rf_d;
         busy_q <= busy_d;
      end
   assign busy_vec = busy_q;
   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0] a;
      logic          hit, byp;
      assign a   = ra[k*AW +: AW];
      assign hit = live(a);
`ifdef REGFILE_BYPASS_EN
      assign byp = wr_ok && wa == a;
`else
      assign byp = 1'b0;
`endif
      assign rd[k*WIDTH +: WIDTH] = byp ? wd : hit ? rf_q[a] : '0;
      assign rbusy[k]             = byp ? (iss_ok && iss_a == a) : hit && busy_q[a];
   end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: vector table, directed corner sequences and a randomized run against a reference model.
module tb_regfile_sb;
   localparam bit BYP =
`ifdef REGFILE_BYPASS_EN
      1'b1;
`else
      1'b0;
`endif
   logic        clk = 1'b0, reset_n = 1'b0;
   logic        we0, iss0;
   logic [4:0]  wa0, isa0;
   logic [31:0] wd0, bv0;
   logic [9:0]  ra0;
   logic [63:0] rd0;
   logic [1:0]  rb0;
   logic        we1, iss1;
   logic [4:0]  wa1, isa1;
   logic [15:0] wd1;
   logic [19:0] ra1;
   logic [63:0] rd1;
   logic [3:0]  rb1;
   logic [23:0] bv1;
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   regfile_sb u0 (
      .clk(clk), .reset_n(reset_n), .we(we0), .wa(wa0), .wd(wd0), .iss(iss0), .iss_a(isa0),
      .ra(ra0), .rd(rd0), .rbusy(rb0), .busy_vec(bv0)
   );
   regfile_sb #(.WIDTH(16), .DEPTH(24), .NREAD(4), .ZERO_REG(0)) u1 (
      .clk(clk), .reset_n(reset_n), .we(we1), .wa(wa1), .wd(wd1), .iss(iss1), .iss_a(isa1),
      .ra(ra1), .rd(rd1), .rbusy(rb1), .busy_vec(bv1)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model for u0 (32 x 32, register 0 hard-wired to zero).
   logic [31:0] m_rf [32];
   logic        m_busy [32];

   function automatic logic [31:0] m_rd(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (BYP && we0 && wa0 == a) return wd0;
      return m_rf[a];
   endfunction

   function automatic logic m_rb(input logic [4:0] a);
      if (a == 0) return 1'b0;
      if (BYP && we0 && wa0 == a) return iss0 && isa0 == a;
      return m_busy[a];
   endfunction

   function automatic logic [31:0] m_bv();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic m_step();
      if (we0 && wa0 != 0) begin
         m_rf[wa0]   = wd0;
         m_busy[wa0] = 1'b0;
      end
      if (iss0 && isa0 != 0) m_busy[isa0] = 1'b1;
   endtask

   task automatic m_clear();
      for (int i = 0; i < 32; i++) begin
         m_rf[i]   = 32'h0;
         m_busy[i] = 1'b0;
      end
   endtask

   function automatic logic [4:0] pick();
      return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
   endfunction

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        iss;
      logic [4:0]  isa;
      logic [4:0]  r0, r1;
      logic [31:0] e0, e1;
      logic        b0, b1;
      logic [31:0] bv;
   } vec_t;
   vec_t tbl [12];

   initial begin
      tbl[0]  = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 5'd5, 5'd0, BYP ? 32'h1234 : 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd5, 5'd7, 32'h1234, 32'h0, 1'b0, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5, 32'h0, 32'h1234, 1'b1, 1'b0, 32'h80};
      tbl[3]  = '{1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 5'd7, 5'd7, BYP ? 32'h77 : 32'h0, BYP ? 32'h77 : 32'h0, 1'b1, 1'b1, 32'h80};
      tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h77, 32'h77, 1'b1, 1'b1, 32'h80};
      tbl[5]  = '{1'b1, 5'd7, 32'h88, 1'b0, 5'd0, 5'd7, 5'd5, BYP ? 32'h88 : 32'h77, 32'h1234, !BYP, 1'b0, 32'h80};
      tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5, 32'h88, 32'h1234, 1'b0, 1'b0, 32'h0};
      tbl[7]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
      tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0, 32'h88, 1'b0, 1'b0, 32'h0};
      tbl[9]  = '{1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 5'd9, 5'd9, BYP ? 32'h11 : 32'h0, BYP ? 32'h11 : 32'h0, BYP, BYP, 32'h0};
      tbl[10] = '{1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd5, 5'd9, 32'h1234, BYP ? 32'hA5A5A5A5 : 32'h11, 1'b0, !BYP, 32'h200};
      tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd9, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};

      // Reset held with active writes and issues: everything must read zero.
      we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; iss0 = 1'b1; isa0 = 5'd5; ra0 = {5'd5, 5'd5};
      we1 = 1'b1; wa1 = 5'd23; wd1 = 16'hBEEF; iss1 = 1'b1; isa1 = 5'd23; ra1 = {4{5'd23}};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst rd0", rd0, 64'h0);
      chk("rst rbusy0", rb0, 2'b00);
      chk("rst busy_vec0", bv0, 32'h0);
      chk("rst rd1", rd1, 64'h0);
      chk("rst busy_vec1", bv1, 24'h0);
      we0 = 1'b0; iss0 = 1'b0; we1 = 1'b0; iss1 = 1'b0;
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) begin
         we0 = tbl[i].we; wa0 = tbl[i].wa; wd0 = tbl[i].wd;
         iss0 = tbl[i].iss; isa0 = tbl[i].isa; ra0 = {tbl[i].r1, tbl[i].r0};
         @(negedge clk);
         chk($sformatf("vec%0d rd[0]", i), rd0[31:0], tbl[i].e0);
         chk($sformatf("vec%0d rd[1]", i), rd0[63:32], tbl[i].e1);
         chk($sformatf("vec%0d rbusy", i), rb0, {tbl[i].b1, tbl[i].b0});
         chk($sformatf("vec%0d busy_vec", i), bv0, tbl[i].bv);
         tick();
      end
      we0 = 1'b0; iss0 = 1'b0;

      // Odd geometry: 24 x 16, four ports, register 0 is ordinary storage.
      we1 = 1'b1; wa1 = 5'd23; wd1 = 16'hBEEF; iss1 = 1'b1; isa1 = 5'd3; ra1 = {4{5'd27}};
      @(negedge clk);
      chk("geo oor rd", rd1, 64'h0);
      tick();
      we1 = 1'b1; wa1 = 5'd27; wd1 = 16'h1111; iss1 = 1'b1; isa1 = 5'd27; ra1 = {4{5'd27}};
      @(negedge clk);
      chk("geo oor bypass rd", rd1, 64'h0);
      chk("geo oor rbusy", rb1, 4'b0000);
      chk("geo busy_vec a", bv1, 24'h8);
      tick();
      we1 = 1'b1; wa1 = 5'd0; wd1 = 16'hFFFF; iss1 = 1'b1; isa1 = 5'd0; ra1 = {4{5'd23}};
      @(negedge clk);
      chk("geo all ports 23", rd1, {4{16'hBEEF}});
      chk("geo busy_vec b", bv1, 24'h8);
      chk("geo rbusy 23", rb1, 4'b0000);
      tick();
      we1 = 1'b0; iss1 = 1'b0; ra1 = {5'd0, 5'd23, 5'd27, 5'd3};
      @(negedge clk);
      chk("geo mixed rd", rd1, {16'hFFFF, 16'hBEEF, 16'h0000, 16'h0000});
      chk("geo mixed rbusy", rb1, 4'b1001);
      chk("geo busy_vec c", bv1, 24'h9);
      tick();

      // Fill u0, then drop reset between edges.
      for (int i = 1; i < 32; i++) begin
         we0 = 1'b1; wa0 = 5'(i); wd0 = 32'(i) * 32'h01010101; iss0 = 1'b1; isa0 = 5'(i);
         tick();
      end
      we0 = 1'b0; iss0 = 1'b0; ra0 = {5'd31, 5'd1};
      @(negedge clk);
      chk("fill busy_vec", bv0, 32'hFFFFFFFE);
      chk("fill rd", rd0, {32'h1F1F1F1F, 32'h01010101});
      chk("fill rbusy", rb0, 2'b11);
      @(posedge clk);
      #3;
      reset_n = 1'b0; we0 = 1'b1; wa0 = 5'd1; wd0 = 32'hCAFEF00D; iss0 = 1'b1; isa0 = 5'd1;
      #1;
      chk("async rst rd0", rd0, 64'h0);
      chk("async rst rbusy0", rb0, 2'b00);
      chk("async rst busy_vec0", bv0, 32'h0);
      chk("async rst rd1", rd1, 64'h0);
      chk("async rst busy_vec1", bv1, 24'h0);
      @(posedge clk);
      @(negedge clk);
      we0 = 1'b0; iss0 = 1'b0;
      reset_n = 1'b1;
      m_clear();
      tick();

      for (int n = 0; n < 400; n++) begin
         we0 = 1'($urandom_range(0, 1)); wa0 = pick(); wd0 = $urandom();
         iss0 = ($urandom_range(0, 2) == 0); isa0 = pick(); ra0 = {pick(), pick()};
         @(negedge clk);
         chk($sformatf("rnd%0d rd[0]", n), rd0[31:0], m_rd(ra0[4:0]));
         chk($sformatf("rnd%0d rd[1]", n), rd0[63:32], m_rd(ra0[9:5]));
         chk($sformatf("rnd%0d rbusy", n), rb0, {m_rb(ra0[9:5]), m_rb(ra0[4:0])});
         chk($sformatf("rnd%0d busy_vec", n), bv0, m_bv());
         m_step();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
